// File: rtl/mt_rng_stream_if.sv
// Stream interface of the MT19937 generator: reseed control, busy flag,
// valid/ready output word and delivered-word counter.
interface mt_rng_stream_if #(
  parameter int OUT_W = 32
);
  logic             seed_load;
  logic [31:0]      seed_in;
  logic             busy;
  logic             rand_valid;
  logic             rand_ready;
  logic [OUT_W-1:0] rand_data;
  logic [31:0]      gen_count;

  modport master (
    input  seed_load, seed_in, rand_ready,
    output busy, rand_valid, rand_data, gen_count
  );

  modport slave (
    output seed_load, seed_in, rand_ready,
    input  busy, rand_valid, rand_data, gen_count
  );
endinterface

// File: rtl/mt_rng_stream.sv
// MT19937 generator with incremental twist, runtime reseed, output FIFO and
// 32/64-bit output packing.
// Optional delivered-word counter: define MT_RNG_STREAM_CNT_EN.
// Without it gen_count reads 32'd0 and no counter exists.
module mt_rng_stream #(
  parameter logic [31:0] SEED       = 32'd5489,
  parameter int          OUT_W      = 32,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  mt_rng_stream_if.master rng_if
);
  localparam int N   = 624;
  localparam int WPE = OUT_W / 32;            // 32-bit words per FIFO entry
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int OW  = 16;                    // occupancy arithmetic width

  if (OUT_W != 32 && OUT_W != 64) begin : g_bad_out_w
    $error("mt_rng_stream: OUT_W must be 32 or 64");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mt_rng_stream: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  function automatic logic [31:0] init_next(input logic [31:0] p, input logic [9:0] k);
    return 32'd1812433253 * (p ^ (p >> 5'd30)) + {22'd0, k};
  endfunction

  function automatic logic [31:0] twist(input logic [31:0] cur, input logic [31:0] nxt,
                                        input logic [31:0] far);
    logic [31:0] y;
    y = {cur[31], nxt[30:0]};
    return far ^ (y >> 5'd1) ^ (y[0] ? 32'h9908B0DF : 32'h00000000);
  endfunction

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x >> 5'd11);
    y = y ^ ((y << 5'd7) & 32'h9D2C5680);
    y = y ^ ((y << 5'd15) & 32'hEFC60000);
    y = y ^ (y >> 5'd18);
    return y;
  endfunction

  // State array and control
  logic [31:0] mt_q [0:N-1];
  state_e      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [31:0] cur_q, cur_d;        // INIT: previous word; RUN: old mt[idx]
  logic [31:0] seed_q;
  logic [9:0]  idx_p1_s, idx_far_s;
  logic [31:0] rd_nxt_s, rd_far_s, twist_s, init_word_s, mt_wdata_s;
  logic        mt_we_s, issue_s, issue_ok_s;

  // Pipeline, packing and FIFO
  logic              v1_q, v2_q;
  logic [31:0]       s1_q, t2_q;
  logic              half_cnt_s, push_s, pop_s;
  logic [OUT_W-1:0]  push_data_s;
  logic [OUT_W-1:0]  fifo_q [0:FIFO_DEPTH-1];
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       count_q;
  logic [OW-1:0]     occ_s;

  assign idx_p1_s    = (idx_q == 10'd623) ? 10'd0 : idx_q + 10'd1;
  assign idx_far_s   = (idx_q < 10'd227) ? idx_q + 10'd397 : idx_q - 10'd227;
  // Async reads: mt[i+1] is still old this pass, mt[i+397] wraps onto words
  // already rewritten in this pass, exactly as the reference recurrence needs.
  assign rd_nxt_s    = mt_q[idx_p1_s];
  assign rd_far_s    = mt_q[idx_far_s];
  assign twist_s     = twist(cur_q, rd_nxt_s, rd_far_s);
  assign init_word_s = (idx_q == 10'd0) ? seed_q : init_next(cur_q, idx_q);

  assign pop_s = (count_q != {(PW+1){1'b0}}) & rng_if.rand_ready;
  // Words already committed (FIFO + half pair + pipeline) after this cycle's pop.
  assign occ_s = (OW'(count_q) << (WPE - 1)) + OW'(half_cnt_s) + OW'(v1_q) + OW'(v2_q)
               - (OW'(pop_s) << (WPE - 1));
  assign issue_ok_s = (occ_s < OW'(FIFO_DEPTH * WPE));

  // Next-state logic: INIT fills the array, RUN twists one index per issue.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    mt_we_s    = 1'b0;
    mt_wdata_s = init_word_s;
    issue_s    = 1'b0;
    case (state_q)
      S_INIT: begin
        mt_we_s    = 1'b1;
        mt_wdata_s = init_word_s;
        if (idx_q == 10'd623) begin
          state_d = S_RUN;
          idx_d   = 10'd0;
          cur_d   = seed_q;               // mt[0] is the seed itself
        end else begin
          idx_d = idx_q + 10'd1;
          cur_d = init_word_s;
        end
      end
      S_RUN: begin
        if (issue_ok_s) begin
          issue_s    = 1'b1;
          mt_we_s    = 1'b1;
          mt_wdata_s = twist_s;
          idx_d      = idx_p1_s;
          cur_d      = rd_nxt_s;
        end else begin
          issue_s = 1'b0;
        end
      end
      default: begin
        state_d = S_INIT;
        idx_d   = 10'd0;
      end
    endcase
  end

  // Control registers; rst has priority over seed_load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= 10'd0;
      cur_q   <= 32'd0;
      seed_q  <= SEED;
    end else if (rng_if.seed_load) begin
      state_q <= S_INIT;
      idx_q   <= 10'd0;
      cur_q   <= 32'd0;
      seed_q  <= rng_if.seed_in;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
    end
  end

  // State array write port.
  always_ff @(posedge clk) begin
    if (mt_we_s) mt_q[idx_q] <= mt_wdata_s;
  end

  // Two-stage pipeline: register the twisted word, then its tempered value.
  always_ff @(posedge clk) begin
    if (rst || rng_if.seed_load) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= 32'd0;
      t2_q <= 32'd0;
    end else begin
      v1_q <= issue_s;
      s1_q <= twist_s;
      v2_q <= v1_q;
      t2_q <= temper(s1_q);
    end
  end

  if (OUT_W == 64) begin : g_pack64
    logic        half_valid_q;
    logic [31:0] half_q;
    // Hold the first word of a pair until the second one arrives.
    always_ff @(posedge clk) begin
      if (rst || rng_if.seed_load) begin
        half_valid_q <= 1'b0;
        half_q       <= 32'd0;
      end else if (v2_q) begin
        half_valid_q <= ~half_valid_q;
        if (!half_valid_q) half_q <= t2_q;
      end
    end
    assign half_cnt_s  = half_valid_q;
    assign push_s      = v2_q & half_valid_q;
    assign push_data_s = {half_q, t2_q};
  end else begin : g_pack32
    assign half_cnt_s  = 1'b0;
    assign push_s      = v2_q;
    assign push_data_s = t2_q;
  end

  // Output FIFO; throttled issue guarantees a push never meets a full FIFO
  // unless a pop happens in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= {PW{1'b0}};
      rd_q    <= {PW{1'b0}};
      count_q <= {(PW+1){1'b0}};
      for (int j = 0; j < FIFO_DEPTH; j++) fifo_q[j] <= {OUT_W{1'b0}};
    end else if (rng_if.seed_load) begin
      wr_q    <= {PW{1'b0}};
      rd_q    <= {PW{1'b0}};
      count_q <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        fifo_q[wr_q] <= push_data_s;
        wr_q         <= wr_q + PW'(1'b1);
      end
      if (pop_s) rd_q <= rd_q + PW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (PW+1)'(1'b1);
        2'b01:   count_q <= count_q - (PW+1)'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef MT_RNG_STREAM_CNT_EN
  logic [31:0] gen_cnt_q;
  // Count accepted transfers; reseed clears, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst || rng_if.seed_load) gen_cnt_q <= 32'd0;
    else if (pop_s)             gen_cnt_q <= gen_cnt_q + 32'd1;
  end
  assign rng_if.gen_count = gen_cnt_q;
`else
  assign rng_if.gen_count = 32'd0;
`endif

  assign rng_if.busy       = (state_q == S_INIT);
  assign rng_if.rand_valid = (count_q != {(PW+1){1'b0}});
  assign rng_if.rand_data  = fifo_q[rd_q];
endmodule

// File: tb/tb_mt_rng_stream.sv
// Directed bench for mt_rng_stream: reference MT19937 words, backpressure,
// reseed and 64-bit packing.
module tb_mt_rng_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mt_rng_stream_if #(.OUT_W(32)) bus32 ();
  mt_rng_stream_if #(.OUT_W(64)) bus64 ();

  mt_rng_stream #(.SEED(32'd5489), .OUT_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rng_if(bus32)
  );
  mt_rng_stream #(.SEED(32'd5489), .OUT_W(64), .FIFO_DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .rng_if(bus64)
  );

`ifdef MT_RNG_STREAM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [31:0] ref5 [0:4] = '{32'd3499211612, 32'd581869302, 32'd3890346734,
                              32'd3586334585, 32'd545404204};
  logic [31:0] seq [0:699];
  logic [63:0] w64 [0:1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus32.seed_load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (!bus32.rand_valid && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 64'(bus32.rand_valid), 64'd1);
  endtask

  initial begin
    int cyc, n, n64, gaps, guard, stall_left, unstable;
    logic        held_valid;
    logic [31:0] held_data, last;

    rst = 1'b1;
    bus32.seed_load = 1'b0; bus32.seed_in = 32'd0; bus32.rand_ready = 1'b0;
    bus64.seed_load = 1'b0; bus64.seed_in = 32'd0; bus64.rand_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 64'(bus32.busy), 64'd1);
    check("rst_valid", 64'(bus32.rand_valid), 64'd0);
    check("rst_data", 64'(bus32.rand_data), 64'd0);
    check("rst_count", 64'(bus32.gen_count), 64'd0);
    check("rst_data64", bus64.rand_data, 64'd0);

    // Continuous consumer: latency, first words, 10000th word, no gaps
    rst = 1'b0;
    bus32.rand_ready = 1'b1;
    cyc = 0;
    while (!bus32.rand_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("first_valid_latency_ok", 64'(cyc <= 640), 64'd1);
    check("busy_low_at_first_valid", 64'(bus32.busy), 64'd0);
    n = 0; n64 = 0; gaps = 0; guard = 0; last = 32'd0;
    while (n < 10000 && guard < 20000) begin
      if (bus32.rand_valid) begin
        if (n < 700) seq[n] = bus32.rand_data;
        if (n < 5) check($sformatf("word%0d", n), 64'(bus32.rand_data), 64'(ref5[n]));
        if (n == 9999) last = bus32.rand_data;
        n++;
      end else begin
        gaps++;
      end
      if (bus64.rand_valid && n64 < 2) begin
        w64[n64] = bus64.rand_data;
        n64++;
      end
      @(negedge clk);
      guard++;
    end
    check("transfers_10000", 64'(n), 64'd10000);
    check("word10000", 64'(last), 64'd4123659995);
    check("no_gaps", 64'(gaps), 64'd0);
    check("gen_count_10000", 64'(bus32.gen_count), CNT_EN ? 64'd10000 : 64'd0);
    check("w64_count", 64'(n64), 64'd2);
    check("w64_first", w64[0], 64'hD091BB5C22AE9EF6);
    check("w64_second", w64[1], {32'd3890346734, 32'd3586334585});

    // Random backpressure with long stalls: same sequence, stable data
    do_reset();
    bus32.rand_ready = 1'b0;
    wait_valid("stall_first", cyc);
    n = 0; guard = 0; stall_left = 0; unstable = 0; held_valid = 1'b0; held_data = 32'd0;
    while (n < 700 && guard < 20000) begin
      if (stall_left > 0) begin
        bus32.rand_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 15) == 0) begin
        stall_left = $urandom_range(8, 30);
        bus32.rand_ready = 1'b0;
      end else begin
        bus32.rand_ready = 1'($urandom_range(0, 1));
      end
      if (held_valid && (!bus32.rand_valid || bus32.rand_data !== held_data)) unstable++;
      if (bus32.rand_valid && bus32.rand_ready) begin
        check($sformatf("stall_seq%0d", n), 64'(bus32.rand_data), 64'(seq[n]));
        n++;
        held_valid = 1'b0;
      end else begin
        held_valid = bus32.rand_valid;
        held_data  = bus32.rand_data;
      end
      @(negedge clk);
      guard++;
    end
    check("stall_transfers", 64'(n), 64'd700);
    check("stall_stable", 64'(unstable), 64'd0);

    // Reseed with seed_in=1 after 50 words
    do_reset();
    bus32.rand_ready = 1'b1;
    wait_valid("reseed_first", cyc);
    n = 0; guard = 0;
    while (n < 50 && guard < 1000) begin
      if (bus32.rand_valid) n++;
      @(negedge clk);
      guard++;
    end
    check("pre_reseed_count", 64'(bus32.gen_count), CNT_EN ? 64'd50 : 64'd0);
    bus32.seed_load = 1'b1;
    bus32.seed_in   = 32'd1;
    @(negedge clk);
    bus32.seed_load = 1'b0;
    bus32.seed_in   = 32'd0;
    check("reseed_valid", 64'(bus32.rand_valid), 64'd0);
    check("reseed_busy", 64'(bus32.busy), 64'd1);
    check("reseed_count", 64'(bus32.gen_count), 64'd0);
    wait_valid("reseed_new", cyc);
    check("seed1_word0", 64'(bus32.rand_data), 64'd1791095845);

    // Reseed mid-INIT restarts INIT from the new seed
    do_reset();
    repeat (100) @(negedge clk);
    check("mid_init_busy", 64'(bus32.busy), 64'd1);
    bus32.seed_load = 1'b1;
    bus32.seed_in   = 32'd1;
    @(negedge clk);
    bus32.seed_load = 1'b0;
    wait_valid("midinit_reseed", cyc);
    check("midinit_seed1_word0", 64'(bus32.rand_data), 64'd1791095845);

    // rst and seed_load together mid-INIT: rst wins, SEED is used
    do_reset();
    repeat (200) @(negedge clk);
    rst = 1'b1;
    bus32.seed_load = 1'b1;
    bus32.seed_in   = 32'd1;
    @(negedge clk);
    rst = 1'b0;
    bus32.seed_load = 1'b0;
    wait_valid("rst_and_seed", cyc);
    check("rst_wins_word0", 64'(bus32.rand_data), 64'd3499211612);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
